// File: rtl/cordic_sqrt_par_if.sv
//----------------------------------------------------------------------------
// cordic_sqrt_par_if
// Start/done handshake bundle for the cordic_sqrt_par square-root engine.
// Revision: 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

interface cordic_sqrt_par_if #(
    parameter int DW = 16
);
    logic          start;
    logic [DW-1:0] din;
    logic          busy;
    logic          done;
    logic [DW-1:0] dout;

    // Requester side: issues start/din, observes busy/done/dout
    modport master (output start, output din, input busy, input done, input dout);
    // Engine side
    modport slave  (input start, input din, output busy, output done, output dout);
endinterface

`default_nettype wire

// File: rtl/cordic_sqrt_par.sv
//----------------------------------------------------------------------------
// cordic_sqrt_par
// Sequential square root of an unsigned DW-bit integer using hyperbolic
// CORDIC in vectoring mode. Result is sqrt(din) in Q(DW/2).(DW/2).
// Flow: NORM (even-shift normalise) -> ITER (NITER CORDIC steps) ->
//       MULT (serial gain compensation) -> DNRM (undo normalisation).
// Optional build macro: CORDIC_SQRT_ROUND_EN selects round-half-up in DNRM
// (plain truncation when undefined).
// Revision: 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module cordic_sqrt_par #(
    parameter int            DW    = 16,
    parameter int            FW    = 4,
    parameter int            NITER = 12,
    parameter int            KW    = 20,
    parameter logic [KW-1:0] KINV  = 20'h9A8F4
) (
    input  logic             clk,
    input  logic             rstx,
    cordic_sqrt_par_if.slave bus
);

    // Coordinate width: 2 integer bits + DW+FW fraction bits
    localparam int W   = DW + FW + 2;
    localparam int KBW = $clog2(DW);
    localparam int CW  = $clog2((KW > NITER) ? KW : NITER) + 1;
    // Product bit holding 2^-DW: x has DW+FW fraction bits, KINV has KW-1
    localparam int SLO = FW + KW - 1;
    localparam logic [W-1:0] QUARTER = {4'b0001, {(DW+FW-2){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NORM = 3'd1,
        S_ITER = 3'd2,
        S_MULT = 3'd3,
        S_DNRM = 3'd4
    } state_t;

    state_t              state_q;
    logic [DW-1:0]       din_q;
    logic [KBW-1:0]      k_q;
    logic                zero_q;
    logic signed [W-1:0] x_q;
    logic signed [W-1:0] y_q;
    logic [5:0]          sh_q;
    logic                rep_q;
    logic [CW-1:0]       cnt_q;
    logic [W+KW-1:0]     prod_q;
    logic                busy_q;
    logic                done_q;
    logic [DW-1:0]       dout_q;

    logic [KBW-1:0]      k_d;
    logic [DW-1:0]       m_d;
    logic [W-1:0]        mext_d;
    logic signed [W-1:0] x0_d;
    logic signed [W-1:0] y0_d;
    logic signed [W-1:0] xs_d;
    logic signed [W-1:0] ys_d;
    logic signed [W-1:0] x_d;
    logic signed [W-1:0] y_d;
    logic [W:0]          acc_d;
    logic                ovf_d;
    logic [DW-1:0]       s_d;
    logic                rbit_d;
    logic [DW:0]         rsum_d;
    logic [DW-1:0]       res_d;
`ifdef CORDIC_SQRT_ROUND_EN
    logic [KBW-1:0]      kidx_d;
`endif

    // Leading-zero-pair count and initial CORDIC coordinates x0=m+1/4, y0=m-1/4
    always_comb begin
        k_d = '0;
        for (int p = 0; p < DW/2; p++) begin
            if (din_q[2*p +: 2] != 2'b00) k_d = KBW'(DW/2 - 1 - p);
        end
        m_d    = din_q << {k_d, 1'b0};
        mext_d = {2'b00, m_d, {FW{1'b0}}};
        x0_d   = mext_d + QUARTER;
        y0_d   = mext_d - QUARTER;
    end

    // One hyperbolic vectoring step; both updates use the old coordinates
    always_comb begin
        xs_d = x_q >>> sh_q;
        ys_d = y_q >>> sh_q;
        if (!y_q[W-1]) begin
            x_d = x_q - ys_d;
            y_d = y_q - xs_d;
        end else begin
            x_d = x_q + ys_d;
            y_d = y_q + xs_d;
        end
    end

    // Serial multiply step: add x into the upper half when the multiplier LSB is set
    always_comb begin
        acc_d = {1'b0, prod_q[W+KW-1:KW]} + (prod_q[0] ? {1'b0, x_q} : '0);
    end

    // Extract s = sqrt(m) in Q0.DW, saturating a product that reached 1.0, then denormalise
    always_comb begin
        ovf_d = |prod_q[W+KW-1:SLO+DW];
        s_d   = ovf_d ? '1 : prod_q[SLO +: DW];
`ifdef CORDIC_SQRT_ROUND_EN
        kidx_d = k_q - KBW'(1);
        rbit_d = (k_q == '0) ? prod_q[SLO-1] : s_d[kidx_d];
`else
        rbit_d = 1'b0;
`endif
        rsum_d = {1'b0, s_d >> k_q} + {{DW{1'b0}}, rbit_d};
        res_d  = rsum_d[DW] ? '1 : rsum_d[DW-1:0];
    end

    // Control FSM and datapath registers; start in any state (re)launches a job
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            state_q <= S_IDLE;
            din_q   <= '0;
            k_q     <= '0;
            zero_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sh_q    <= '0;
            rep_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                end
                S_NORM: begin
                    x_q     <= x0_d;
                    y_q     <= y0_d;
                    k_q     <= k_d;
                    zero_q  <= (din_q == '0);
                    sh_q    <= 6'd1;
                    rep_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    // Shift indices 4, 13 and 40 run twice to keep convergence
                    if ((sh_q == 6'd4 || sh_q == 6'd13 || sh_q == 6'd40) && !rep_q) begin
                        rep_q <= 1'b1;
                    end else begin
                        rep_q <= 1'b0;
                        sh_q  <= sh_q + 6'd1;
                    end
                    if (cnt_q == CW'(NITER - 1)) begin
                        cnt_q   <= '0;
                        prod_q  <= {{W{1'b0}}, KINV};
                        state_q <= S_MULT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_MULT: begin
                    prod_q <= {acc_d, prod_q[KW-1:1]};
                    if (cnt_q == CW'(KW - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_DNRM;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DNRM: begin
                    dout_q  <= zero_q ? '0 : res_d;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (bus.start) begin
                din_q   <= bus.din;
                busy_q  <= 1'b1;
                state_q <= S_NORM;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;

endmodule

`default_nettype wire
